imem_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the instruction memory and the processor core.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned addresses, holding the core in reset until loading finishes.
- Top level drives I_MEM's write port from mem_we/mem_addr/mem_wdata and ORs core_reset into the core's reset.

---
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Receives a byte stream (valid/ready), reads a 2-byte big-endian word
// count, assembles big-endian 32-bit words and writes them to consecutive
// word-aligned addresses while holding the core in reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the core is released.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`endif

  // Largest legal word count, widened by one bit so the compare cannot overflow.
  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             byte_ready_q, byte_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             accept;
  logic [CNT_W-1:0] hdr_count;
  logic [31:0]      next_word;

  // Next-state and next-output computation; every output is registered from
  // the next state so nothing downstream sees combinational glitches.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    word_d       = word_q;
    count_d      = count_q;
    words_d      = words_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    accept       = byte_valid & byte_ready_q;
    hdr_count    = CNT_W'({word_q[7:0], byte_in});
    next_word    = {word_q[23:0], byte_in};

    case (state_q)
      S_IDLE: begin
        lane_d = 2'd0;
        word_d = 32'd0;
        if (start) begin
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (accept) begin
          if (lane_q == 2'd0) begin
            word_d = next_word;
            lane_d = 2'd1;
          end else begin
            count_d = hdr_count;
            lane_d  = 2'd0;
            word_d  = 32'd0;
            if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else if ({1'b0, hdr_count} > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        if (words_q == count_q) begin
          // The final write is on the bus this cycle; leave LOAD next edge.
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_in;
`endif
          if (lane_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = next_word;
            mem_addr_d  = 32'(words_q) << 2;
            words_d     = words_q + CNT_W'(1);
            word_d      = 32'd0;
            lane_d      = 2'd0;
          end else begin
            word_d = next_word;
            lane_d = lane_q + 2'd1;
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Ready is withheld as soon as the last word completes, so no byte past
    // the declared count is ever consumed.
    byte_ready_d = (state_d == S_HDR) ||
                   ((state_d == S_LOAD) && (words_d != count_d));
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_d == S_CHK) begin
      byte_ready_d = 1'b1;
    end
`endif
    core_reset_d = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  // State and output registers with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      word_q       <= 32'd0;
      count_q      <= '0;
      words_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      count_q      <= count_d;
      words_q      <= words_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven load scenarios plus hand-written
// sequences, with a write scoreboard fed by the stimulus side.
module tb_imem_loader;

   localparam int Depth = 256;
   localparam int CntW  = 16;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            startPulse = 1'b0;
   logic [7:0]      byteIn = 8'd0;
   logic            byteValid = 1'b0;
   logic            byteReady;
   logic            memWe;
   logic [31:0]     memAddr;
   logic [31:0]     memWdata;
   logic            coreReset;
   logic            done;
   logic            error;
   logic [CntW-1:0] wordsLoaded;

   typedef struct {
      logic [15:0] hdr;
      int          nWords;
      logic [31:0] seed;
      bit          gaps;
      bit          expErr;
   } vec_t;

   vec_t        vecs[7];
   logic [63:0] expQ[$];
   logic [63:0] expWrite;
   int          nVectors = 0;
   int          nMiscompares = 0;
   int          stallCycles = 0;

   // Free-running clock
   always #5 clock = ~clock;

   imem_loader #(.DEPTH(Depth), .CNT_W(CntW)) dut (
      .clk(clock),
      .reset(reset),
      .start(startPulse),
      .byte_in(byteIn),
      .byte_valid(byteValid),
      .byte_ready(byteReady),
      .mem_we(memWe),
      .mem_addr(memAddr),
      .mem_wdata(memWdata),
      .core_reset(coreReset),
      .done(done),
      .error(error),
      .words_loaded(wordsLoaded)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Every memory write is matched against the next expected {addr, data}
   always @(negedge clock) begin
      if (memWe === 1'b1) begin
         if (expQ.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write", memAddr, memWdata);
         end else begin
            expWrite = expQ.pop_front();
            checkOutput("write_addr", memAddr, expWrite[63:32]);
            checkOutput("write_data", memWdata, expWrite[31:0]);
         end
      end
   end

   // Hard stop in case something hangs despite the per-byte bounds
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic sendByte(input logic [7:0] b);
      int   waited = 0;
      logic taken = 1'b0;
      byteIn    = b;
      byteValid = 1'b1;
      while (!taken && waited < 50) begin
         taken = byteReady;
         @(negedge clock);
         if (!taken) waited++;
      end
      stallCycles += waited;
      if (!taken) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL byte_accept_timeout: byte %h not taken in 50 cycles, expected acceptance", b);
      end
   endtask

   task automatic sendWord(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) begin
         sendByte(w[31-8*k -: 8]);
         if (gaps) begin
            byteValid = 1'b0;
            @(negedge clock);
         end
      end
   endtask

   task automatic pulseStart();
      startPulse = 1'b1;
      @(negedge clock);
      startPulse = 1'b0;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_byte_ready", 32'(byteReady), 32'd0);
      checkOutput("rst_mem_we", 32'(memWe), 32'd0);
      checkOutput("rst_mem_addr", memAddr, 32'd0);
      checkOutput("rst_mem_wdata", memWdata, 32'd0);
      checkOutput("rst_core_reset", 32'(coreReset), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      checkOutput("rst_words_loaded", 32'(wordsLoaded), 32'd0);
   endtask

   task automatic doReset();
      byteValid  = 1'b0;
      startPulse = 1'b0;
      reset      = 1'b1;
      @(negedge clock);
      checkResetValues();
      reset = 1'b0;
      expQ.delete();
   endtask

   task automatic checkFinal(input bit expDone, input bit expErr, input int expWords);
      repeat (2) @(negedge clock);
      checkOutput("final_done", 32'(done), 32'(expDone));
      checkOutput("final_error", 32'(error), 32'(expErr));
      checkOutput("final_core_reset", 32'(coreReset), 32'(!expDone));
      checkOutput("final_byte_ready", 32'(byteReady), 32'd0);
      checkOutput("final_words_loaded", 32'(wordsLoaded), 32'(expWords));
      checkOutput("final_pending_writes", 32'(expQ.size()), 32'd0);
   endtask

   // Runs one table scenario: header, generated words, optional checksum
   task automatic applyStimulus(input vec_t v);
      logic [7:0]  csum = 8'd0;
      logic [31:0] w;
      pulseStart();
      sendByte(v.hdr[15:8]);
      sendByte(v.hdr[7:0]);
      byteValid = 1'b0;
      if (!v.expErr) begin
         for (int i = 0; i < v.nWords; i++) begin
            w = v.seed + 32'(i) * 32'h01030507;
            expQ.push_back({32'(i) << 2, w});
            csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            sendWord(w, v.gaps);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         sendByte(csum);
`endif
      end else begin
         byteIn    = 8'hAA;
         byteValid = 1'b1;
         repeat (4) @(negedge clock);
      end
      byteValid = 1'b0;
      checkFinal(!v.expErr, v.expErr, v.expErr ? 0 : v.nWords);
   endtask

   initial begin
      logic [7:0] csum;

      vecs[0] = '{hdr: 16'd1,     nWords: 1,   seed: 32'hDEADBEEF, gaps: 1'b0, expErr: 1'b0};
      vecs[1] = '{hdr: 16'd3,     nWords: 3,   seed: 32'h12345678, gaps: 1'b1, expErr: 1'b0};
      vecs[2] = '{hdr: 16'd0,     nWords: 0,   seed: 32'h0,        gaps: 1'b0, expErr: 1'b0};
      vecs[3] = '{hdr: 16'd257,   nWords: 0,   seed: 32'h0,        gaps: 1'b0, expErr: 1'b1};
      vecs[4] = '{hdr: 16'hFFFF,  nWords: 0,   seed: 32'h0,        gaps: 1'b0, expErr: 1'b1};
      vecs[5] = '{hdr: 16'd256,   nWords: 256, seed: 32'h00000001, gaps: 1'b0, expErr: 1'b0};
      vecs[6] = '{hdr: 16'd5,     nWords: 5,   seed: 32'hA5A50F0F, gaps: 1'b1, expErr: 1'b0};

      // Reference program at full rate with exact release timing
      doReset();
      pulseStart();
      sendByte(8'h00);
      sendByte(8'h02);
      expQ.push_back({32'h0, 32'h3C080010});
      expQ.push_back({32'h4, 32'h8D090000});
      stallCycles = 0;
      sendWord(32'h3C080010, 1'b0);
      sendWord(32'h8D090000, 1'b0);
      checkOutput("fullrate_stalls", 32'(stallCycles), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendByte(8'h3C ^ 8'h08 ^ 8'h00 ^ 8'h10 ^ 8'h8D ^ 8'h09 ^ 8'h00 ^ 8'h00);
      byteValid = 1'b0;
      checkFinal(1'b1, 1'b0, 2);
`else
      byteValid = 1'b0;
      checkOutput("last_write_core_reset", 32'(coreReset), 32'd1);
      checkOutput("last_write_done", 32'(done), 32'd0);
      checkOutput("last_write_words", 32'(wordsLoaded), 32'd2);
      @(negedge clock);
      checkOutput("release_core_reset", 32'(coreReset), 32'd0);
      checkOutput("release_done", 32'(done), 32'd1);
      checkOutput("release_byte_ready", 32'(byteReady), 32'd0);
      checkOutput("release_pending_writes", 32'(expQ.size()), 32'd0);
`endif

      // start while DONE must be ignored
      pulseStart();
      @(negedge clock);
      checkOutput("start_in_done_done", 32'(done), 32'd1);
      checkOutput("start_in_done_ready", 32'(byteReady), 32'd0);
      checkOutput("start_in_done_words", 32'(wordsLoaded), 32'd2);

      // Same program with byte_valid toggling every cycle
      doReset();
      pulseStart();
      sendByte(8'h00);
      byteValid = 1'b0;
      @(negedge clock);
      sendByte(8'h02);
      byteValid = 1'b0;
      @(negedge clock);
      expQ.push_back({32'h0, 32'h3C080010});
      expQ.push_back({32'h4, 32'h8D090000});
      sendWord(32'h3C080010, 1'b1);
      sendWord(32'h8D090000, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendByte(8'hA0);
`endif
      byteValid = 1'b0;
      checkFinal(1'b1, 1'b0, 2);

      // Reset in the middle of a load, then a clean reload from address 0
      doReset();
      pulseStart();
      expQ.push_back({32'h0, 32'h3C080010});
      sendByte(8'h00);
      sendByte(8'h02);
      sendWord(32'h3C080010, 1'b0);
      byteValid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checkResetValues();
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midreset_pending_writes", 32'(expQ.size()), 32'd0);
      pulseStart();
      sendByte(8'h00);
      sendByte(8'h02);
      expQ.push_back({32'h0, 32'h3C080010});
      expQ.push_back({32'h4, 32'h8D090000});
      sendWord(32'h3C080010, 1'b0);
      sendWord(32'h8D090000, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendByte(8'hA0);
`endif
      byteValid = 1'b0;
      checkFinal(1'b1, 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum mismatch keeps the written words but refuses to release
      doReset();
      pulseStart();
      sendByte(8'h00);
      sendByte(8'h02);
      expQ.push_back({32'h0, 32'h01020304});
      expQ.push_back({32'h4, 32'h0A0B0C0D});
      sendWord(32'h01020304, 1'b0);
      sendWord(32'h0A0B0C0D, 1'b0);
      csum = 8'h05;
      sendByte(csum);
      byteValid = 1'b0;
      checkFinal(1'b0, 1'b1, 2);

      // Empty program with a wrong checksum byte
      doReset();
      pulseStart();
      sendByte(8'h00);
      sendByte(8'h00);
      sendByte(8'h01);
      byteValid = 1'b0;
      checkFinal(1'b0, 1'b1, 0);
`else
      csum = 8'h00;
      checkOutput("checksum_unused", 32'(csum), 32'(error));
`endif

      // Table-driven scenarios
      for (int i = 0; i < 7; i++) begin
         doReset();
         applyStimulus(vecs[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
